ram_arbiter: RTL and testbench

Shares the single-port data RAM between the CPU core's data port and an external master, such as a debug/program loader or DMA. The core always has priority, because its load path expects the RAM to return data exactly one cycle after the request. The external master normally uses idle slots only. When the external master is starved, the block pauses the core through `running`, waits for the pipeline to drain, and then serves the external master exclusively. It sits between `cpu_core` and the data RAM.

---
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - data RAM arbiter between the core data port and an external master
module ram_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_in,
  output logic        running,
  input  logic [4:0]  core_ram_ctrl,
  input  logic [31:0] core_ram_addr,
  input  logic [31:0] core_ram_din,
  output logic [31:0] core_ram_dout,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [2:0]  ext_funct3,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [4:0]  mem_ctrl,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] STARVE_MAX  = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_LIMIT - 1);
  localparam logic [DW-1:0] DRAIN_LOAD  = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] starve_cnt;
  logic [DW-1:0] drain_cnt;
  logic          core_v;
  logic          denied;

  assign core_v = core_ram_ctrl[0];

  // Both masters see the RAM output directly; the core's load stage and
  // the external read path each expect data exactly one cycle after access.
  assign core_ram_dout = mem_dout;
  assign ext_rdata     = mem_dout;

  // Port mux: the core always wins; the external master takes any idle slot.
  // HOLD grants no extra slots, it only keeps the core paused so idle slots appear.
  always_comb begin
    ext_gnt  = 1'b0;
    mem_ctrl = 5'd0;
    mem_addr = 32'd0;
    mem_din  = 32'd0;
    if (core_v) begin
      mem_ctrl = core_ram_ctrl;
      mem_addr = core_ram_addr;
      mem_din  = core_ram_din;
    end else if (ext_req) begin
      ext_gnt  = 1'b1;
      mem_ctrl = {ext_funct3, ext_we, 1'b1};
      mem_addr = ext_addr;
      mem_din  = ext_wdata;
    end
  end

  assign denied = ext_req & ~ext_gnt;

  // Next-state decode; also needed to register running in the same edge.
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:   if (denied && starve_cnt == STARVE_LAST) state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == '0) state_nx = ST_HOLD;
      ST_HOLD:  if (!ext_req) state_nx = ST_RUN;
      default:  state_nx = ST_RUN;
    endcase
  end

  // FSM, starvation/drain counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      starve_cnt <= '0;
      drain_cnt  <= '0;
      running    <= 1'b0;
      ext_rvalid <= 1'b0;
    end else begin
      state      <= state_nx;
      running    <= run_in && (state_nx == ST_RUN);
      ext_rvalid <= ext_req & ext_gnt & ~ext_we;

      if (!denied)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;

      if (state == ST_RUN && state_nx == ST_DRAIN)
        drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a RAM model and reference model
module tb_ram_arbiter;

  localparam int SL = 8;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_in;
  logic        running;
  logic [4:0]  core_ram_ctrl;
  logic [31:0] core_ram_addr;
  logic [31:0] core_ram_din;
  logic [31:0] core_ram_dout;
  logic        ext_req;
  logic        ext_we;
  logic [2:0]  ext_funct3;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic [4:0]  mem_ctrl;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  ram_arbiter #(.STARVE_LIMIT(SL), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .run_in(run_in), .running(running),
    .core_ram_ctrl(core_ram_ctrl), .core_ram_addr(core_ram_addr),
    .core_ram_din(core_ram_din), .core_ram_dout(core_ram_dout),
    .ext_req(ext_req), .ext_we(ext_we), .ext_funct3(ext_funct3),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Environment RAM: single port, word addressed, one-cycle read latency.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_ctrl[0]) begin
      if (mem_ctrl[1]) ram[mem_addr[9:2]] <= mem_din;
      else             mem_dout <= ram[mem_addr[9:2]];
    end
  end

  typedef struct {
    logic        gnt;
    logic [4:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] din;
    logic        running;
    logic        rvalid;
    logic [31:0] rdata;
    logic        core_chk;
    logic [31:0] core_data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: paused flag plus age since pause, raw denial streak,
  // and a shadow memory holding what each word should contain.
  logic [31:0] ref_mem [0:255];
  bit          m_paused;
  int          m_age;
  int          m_streak;
  bit          m_running;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  bit          m_core_rd;
  logic [31:0] m_core_data;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ext_gnt", {31'd0, ext_gnt}, {31'd0, e.gnt});
      chk("mem_ctrl", {27'd0, mem_ctrl}, {27'd0, e.ctrl});
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_din", mem_din, e.din);
      chk("running", {31'd0, running}, {31'd0, e.running});
      chk("ext_rvalid", {31'd0, ext_rvalid}, {31'd0, e.rvalid});
      if (e.rvalid) chk("ext_rdata", ext_rdata, e.rdata);
      if (e.core_chk) chk("core_ram_dout", core_ram_dout, e.core_data);
    end
  end

  task automatic cycle(input logic rn, input logic ri,
                       input logic cv, input logic cw, input logic [2:0] cf3,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [2:0] ef3,
                       input logic [31:0] ea, input logic [31:0] ed);
    exp_t e;
    bit   g;
    bit   acc;
    bit   wr;
    logic [31:0] a;
    logic [31:0] d;
    rst_n = rn; run_in = ri;
    core_ram_ctrl = {cf3, cw, cv}; core_ram_addr = ca; core_ram_din = cd;
    ext_req = er; ext_we = ew; ext_funct3 = ef3; ext_addr = ea; ext_wdata = ed;

    g = er && !cv;
    acc = cv || g;
    wr = cv ? cw : ew;
    a = cv ? ca : ea;
    d = cv ? cd : ed;
    e.gnt = g;
    e.ctrl = cv ? {cf3, cw, 1'b1} : (g ? {ef3, ew, 1'b1} : 5'd0);
    e.addr = acc ? a : 32'd0;
    e.din = acc ? d : 32'd0;
    e.running = m_running;
    e.rvalid = m_rvalid;
    e.rdata = m_rdata;
    e.core_chk = m_core_rd;
    e.core_data = m_core_data;
    sb.push_back(e);

    @(posedge clk); #1;

    // Memory effect happens regardless of reset: the RAM itself is not reset.
    m_core_rd = cv && !cw;
    m_core_data = ref_mem[ca[9:2]];
    m_rdata = ref_mem[ea[9:2]];
    if (acc && wr) ref_mem[a[9:2]] = d;

    if (!rn) begin
      m_paused = 0; m_age = 0; m_streak = 0; m_running = 0; m_rvalid = 0;
    end else begin
      m_rvalid = g && !ew;
      m_streak = (er && !g) ? m_streak + 1 : 0;
      if (!m_paused) begin
        if (m_streak >= SL) begin m_paused = 1; m_age = 0; end
      end else if (m_age < DC) begin
        m_age++;
      end else if (!er) begin
        m_paused = 0;
      end
      m_running = ri && !m_paused;
    end
  endtask

  task automatic idle(input logic ri);
    cycle(1, ri, 0, 0, 3'd0, 32'd0, 32'd0, 0, 0, 3'd0, 32'd0, 32'd0);
  endtask

  // Core accesses every cycle while the external master keeps asking.
  task automatic starve(input int n, input logic ri);
    for (int i = 0; i < n; i++)
      cycle(1, ri, 1, 1'($urandom_range(0, 1)), 3'd2, {$urandom_range(0, 15), 2'b00}, $urandom,
            1, 0, 3'd2, 32'h40, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 32'd0; ref_mem[i] = 32'd0; end
    mem_dout = 32'd0;
    m_paused = 0; m_age = 0; m_streak = 0; m_running = 0; m_rvalid = 0;
    m_rdata = 32'd0; m_core_rd = 0; m_core_data = 32'd0;
    rst_n = 0; run_in = 0; core_ram_ctrl = 5'd0; core_ram_addr = 32'd0; core_ram_din = 32'd0;
    ext_req = 0; ext_we = 0; ext_funct3 = 3'd0; ext_addr = 32'd0; ext_wdata = 32'd0;
    @(posedge clk); #1;

    // Idle core: external write then read back.
    cycle(1, 1, 0, 0, 3'd2, 32'd0, 32'd0, 1, 1, 3'd2, 32'h100, 32'hDEADBEEF);
    cycle(1, 1, 0, 0, 3'd2, 32'd0, 32'd0, 1, 0, 3'd2, 32'h100, 32'd0);
    idle(1);

    // Conflict: core load at 0x40 with external request, then idle slot.
    cycle(1, 1, 0, 1, 3'd2, 32'd0, 32'h12345678, 0, 0, 3'd0, 32'd0, 32'd0);
    cycle(1, 1, 0, 1, 3'd2, 32'h40, 32'h0BADF00D, 0, 0, 3'd0, 32'd0, 32'd0);
    cycle(1, 1, 1, 0, 3'd2, 32'h40, 32'd0, 1, 0, 3'd2, 32'h100, 32'd0);
    cycle(1, 1, 0, 0, 3'd2, 32'd0, 32'd0, 1, 0, 3'd2, 32'h100, 32'd0);
    idle(1);

    // Starvation into HOLD, a core access in HOLD, granted read, then exit.
    starve(SL + DC + 2, 1);
    cycle(1, 1, 0, 0, 3'd0, 32'd0, 32'd0, 1, 0, 3'd2, 32'h100, 32'd0);
    cycle(1, 1, 1, 0, 3'd2, 32'h40, 32'd0, 1, 0, 3'd2, 32'h100, 32'd0);
    cycle(1, 0, 0, 0, 3'd0, 32'd0, 32'd0, 1, 1, 3'd2, 32'h8, 32'hCAFE0001);
    idle(1);
    idle(1);

    // Reset mid-HOLD during an external read grant.
    starve(SL + DC + 1, 1);
    cycle(0, 1, 0, 0, 3'd0, 32'd0, 32'd0, 1, 0, 3'd2, 32'h8, 32'd0);
    idle(1);
    idle(1);

    // run_in low while starving through DRAIN and HOLD, then exit.
    starve(SL + DC + 3, 0);
    cycle(1, 0, 0, 0, 3'd0, 32'd0, 32'd0, 1, 0, 3'd2, 32'h8, 32'd0);
    idle(0);
    idle(1);

    // Randomized traffic with busy core phases to provoke starvation.
    for (int i = 0; i < 3000; i++) begin
      int busy_pct;
      logic cv;
      busy_pct = ((i / 64) % 2 == 0) ? 40 : 95;
      cv = ($urandom_range(0, 99) < busy_pct);
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) != 0),
            cv, 1'($urandom_range(0, 1)), 3'($urandom), {$urandom_range(0, 15), 2'b00}, $urandom,
            ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 3'($urandom),
            {$urandom_range(0, 15), 2'b00}, $urandom);
    end
    idle(1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
